// File: rtl/vt52_pkg.sv
// Shared definitions for the text-mode character fetch path: geometry defaults,
// address widths, fetch FSM states and the font ROM address composition.
// Latency: n/a (package). Backpressure: n/a.
package vt52_pkg;

    localparam int COLS_DEF   = 80;   // characters per text row
    localparam int ROWS_DEF   = 24;   // text rows
    localparam int CHAR_W_DEF = 8;    // pixels per character cell

    localparam int BUF_AW  = 11;      // character buffer address width
    localparam int FONT_AW = 12;      // font ROM address width
    localparam int CODE_W  = 8;       // character code / font byte width
    localparam int COL_W   = 7;
    localparam int ROW_W   = 5;
    localparam int LINE_W  = 4;       // scanline within a character cell

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREFETCH = 2'd1,
        ACTIVE   = 2'd2
    } fetch_state_t;

    // Font ROM is organised as 16 scanlines per glyph, glyph-major.
    function automatic logic [FONT_AW-1:0] font_addr_of(input logic [CODE_W-1:0] code,
                                                        input logic [LINE_W-1:0] line);
        return {code, line};
    endfunction

endpackage

// File: rtl/char_fetch_ctrl_if.sv
// Bundle between the character fetch controller and its surroundings: line
// request from video timing, buffer/font ROM read ports, cursor state, pixel out.
// Latency: n/a (wires only). Backpressure: none; everything is fixed-rate.
// master: the fetch controller (drives ROM/buffer addresses and pixel stream).
// slave : the environment (timing generator, memories, pixel sink).
interface char_fetch_ctrl_if;
    import vt52_pkg::*;

    logic                  line_start;
    logic [ROW_W-1:0]      text_row;
    logic [LINE_W-1:0]     char_line;
    logic [BUF_AW-1:0]     buf_addr;
    logic [CODE_W-1:0]     buf_data;
    logic [FONT_AW-1:0]    font_addr;
    logic [CODE_W-1:0]     font_data;
    logic                  cursor_en;
    logic                  cursor_blink;
    logic [COL_W-1:0]      cursor_col;
    logic [ROW_W-1:0]      cursor_row;
    logic                  pixel;
    logic                  pixel_valid;
    logic                  line_done;

    modport master (
        input  line_start, text_row, char_line, buf_data, font_data,
               cursor_en, cursor_blink, cursor_col, cursor_row,
        output buf_addr, font_addr, pixel, pixel_valid, line_done
    );

    modport slave (
        output line_start, text_row, char_line, buf_data, font_data,
               cursor_en, cursor_blink, cursor_col, cursor_row,
        input  buf_addr, font_addr, pixel, pixel_valid, line_done
    );

endinterface

// File: rtl/pixel_shifter.sv
// 8-bit MSB-first pixel shift register with a next-byte holding register.
// Latency: out shows the loaded byte's MSB the cycle after load; zeros shift in.
// Backpressure: none; load/shift/capture are strobes from the fetch sequencer.
// Ports: clr (sync clear both regs), cap/cap_dat (fill holding reg),
//        load (load_direct ? direct_dat : holding reg), shift, out (MSB).
module pixel_shifter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       cap,
    input  logic [7:0] cap_dat,
    input  logic       load,
    input  logic       load_direct,
    input  logic [7:0] direct_dat,
    input  logic       shift,
    output logic       out
);

    logic [7:0] shreg_q;
    logic [7:0] next_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q <= '0;
            next_q  <= '0;
        end else if (clr) begin
            shreg_q <= '0;
            next_q  <= '0;
        end else begin
            if (cap)
                next_q <= cap_dat;
            if (load)
                shreg_q <= load_direct ? direct_dat : next_q;
            else if (shift)
                shreg_q <= {shreg_q[6:0], 1'b0};   // zero fill covers cells wider than 8
        end
    end

    assign out = shreg_q[7];

endmodule

// File: rtl/char_fetch_ctrl.sv
// Character-cell fetch sequencer for one scanline: buffer read -> font ROM read -> pixel serializer.
// Latency: line_start at t gives first pixel at t+5, line_done at t+5+COLS*CHAR_W.
// Backpressure: none; fixed-rate, one font access per CHAR_W pixels, line_start restarts at any time.
// Ports: clk, rst_n (async active-low), bus (char_fetch_ctrl_if.master: line request,
//        buffer/font read ports, cursor state, pixel/pixel_valid/line_done).
module char_fetch_ctrl
    import vt52_pkg::*;
#(
    parameter int COLS   = COLS_DEF,
    parameter int ROWS   = ROWS_DEF,
    parameter int CHAR_W = CHAR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    char_fetch_ctrl_if.master bus
);

    localparam int CNT_W = $clog2(CHAR_W);   // also holds the 0..3 prefetch step (CHAR_W >= 5)

    fetch_state_t       state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [COL_W-1:0]   col_q;               // column currently being displayed
    logic [ROW_W-1:0]   row_q;
    logic [LINE_W-1:0]  line_q;
    logic [BUF_AW-1:0]  row_base_q;
    logic [BUF_AW-1:0]  buf_addr_q;
    logic [FONT_AW-1:0] font_addr_q;
    logic               line_done_q;

    logic [ROW_W-1:0]   row_clamped;
    logic [BUF_AW-1:0]  start_base;
    logic [COL_W-1:0]   next_col;
    logic               last_pix, last_col;
    logic               hit_col0, hit_next;
    logic               sh_load, sh_load_direct, sh_cap, sh_shift, sh_out;

    assign row_clamped = (32'(bus.text_row) >= ROWS) ? ROW_W'(ROWS - 1) : bus.text_row;
    assign start_base  = BUF_AW'(row_clamped) * BUF_AW'(COLS);
    assign next_col    = col_q + COL_W'(1);
    assign last_pix    = (cnt_q == CNT_W'(CHAR_W - 1));
    assign last_col    = (col_q == COL_W'(COLS - 1));

    // Cursor inversion is applied as a byte enters the shifter path, keyed by
    // the column that byte belongs to (col 0 in prefetch, col+1 otherwise).
    assign hit_col0 = bus.cursor_en & bus.cursor_blink & (bus.cursor_row == row_q)
                    & (bus.cursor_col == '0);
    assign hit_next = bus.cursor_en & bus.cursor_blink & (bus.cursor_row == row_q)
                    & (bus.cursor_col == next_col);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Next state and shifter strobes
    always_comb begin
        state_d        = state_q;
        sh_load        = 1'b0;
        sh_load_direct = 1'b0;
        sh_cap         = 1'b0;
        sh_shift       = 1'b0;
        case (state_q)
            IDLE: ;
            PREFETCH: begin
                // step 3: col 0 font byte is on font_data, goes straight to the shifter
                if (cnt_q == CNT_W'(3)) begin
                    state_d        = ACTIVE;
                    sh_load        = 1'b1;
                    sh_load_direct = 1'b1;
                end
            end
            ACTIVE: begin
                sh_shift = 1'b1;
                sh_cap   = (cnt_q == CNT_W'(3)) && !last_col;
                if (last_pix) begin
                    if (last_col)
                        state_d = IDLE;
                    else
                        sh_load = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // A new request always wins, including mid-line (abort without line_done).
        if (bus.line_start)
            state_d = PREFETCH;
    end

    // Counters and fetch addresses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            col_q       <= '0;
            row_q       <= '0;
            line_q      <= '0;
            row_base_q  <= '0;
            buf_addr_q  <= '0;
            font_addr_q <= '0;
            line_done_q <= 1'b0;
        end else begin
            line_done_q <= 1'b0;
            if (bus.line_start) begin
                row_q      <= row_clamped;
                line_q     <= bus.char_line;
                row_base_q <= start_base;
                buf_addr_q <= start_base;          // col 0 address out at t+1
                cnt_q      <= '0;
                col_q      <= '0;
            end else begin
                case (state_q)
                    PREFETCH: begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(1))
                            font_addr_q <= font_addr_of(bus.buf_data, line_q);
                        if (cnt_q == CNT_W'(3)) begin
                            cnt_q <= '0;
                            // col 1 address must be out during pixel 0 of col 0
                            if (COLS > 1)
                                buf_addr_q <= row_base_q + BUF_AW'(1);
                        end
                    end
                    ACTIVE: begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        // buf_data for col+1 arrives at pixel 1
                        if (cnt_q == CNT_W'(1) && !last_col)
                            font_addr_q <= font_addr_of(bus.buf_data, line_q);
                        if (last_pix) begin
                            cnt_q <= '0;
                            if (last_col) begin
                                line_done_q <= 1'b1;
                            end else begin
                                col_q <= next_col;
                                // next character (col+2) address, unless col+1 is the last one
                                if (col_q != COL_W'(COLS - 2))
                                    buf_addr_q <= row_base_q + BUF_AW'(col_q) + BUF_AW'(2);
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    pixel_shifter u_shifter (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (bus.line_start),
        .cap         (sh_cap),
        .cap_dat     (bus.font_data ^ {8{hit_next}}),
        .load        (sh_load),
        .load_direct (sh_load_direct),
        .direct_dat  (bus.font_data ^ {8{hit_col0}}),
        .shift       (sh_shift),
        .out         (sh_out)
    );

    assign bus.buf_addr    = buf_addr_q;
    assign bus.font_addr   = font_addr_q;
    assign bus.pixel_valid = (state_q == ACTIVE);
    assign bus.pixel       = (state_q == ACTIVE) & sh_out;
    assign bus.line_done   = line_done_q;

endmodule

// File: tb/tb_char_fetch_ctrl.sv
// Directed bench for char_fetch_ctrl with behavioural 1-cycle sync buffer and font ROM.
// Each run logs outputs per cycle relative to the line_start cycle t (index k = t+k).
// Expected values come from hand-derived timing and the bench's own memory contents.
module tb_char_fetch_ctrl;
    import vt52_pkg::*;

    localparam int NCYC = 1300;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    char_fetch_ctrl_if bus();

    char_fetch_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [7:0] cbuf [0:2047];
    logic [7:0] font [0:4095];

    always @(posedge clk) begin
        bus.buf_data  <= cbuf[bus.buf_addr];
        bus.font_data <= font[bus.font_addr];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic        pv_log [0:NCYC];
    logic        px_log [0:NCYC];
    logic        ld_log [0:NCYC];
    logic [10:0] ba_log [0:NCYC];
    logic [11:0] fa_log [0:NCYC];

    int first_v, last_v, v_cnt, ld_cnt, ld_k1, ld_k2;

    // line_start high in cycle t; a second line_start issued in cycle t+restart_at.
    task automatic run_line(input logic [4:0] row, input logic [3:0] line,
                            input int restart_at, input logic [4:0] row2, input logic [3:0] line2);
        @(negedge clk);
        bus.text_row   = row;
        bus.char_line  = line;
        bus.line_start = 1'b1;
        for (int k = 1; k <= NCYC; k++) begin
            @(negedge clk);
            pv_log[k] = bus.pixel_valid;
            px_log[k] = bus.pixel;
            ld_log[k] = bus.line_done;
            ba_log[k] = bus.buf_addr;
            fa_log[k] = bus.font_addr;
            bus.line_start = (k == restart_at);
            if (k == restart_at) begin
                bus.text_row  = row2;
                bus.char_line = line2;
            end
        end
        bus.line_start = 1'b0;
    endtask

    task automatic scan_logs(input int from);
        first_v = -1; last_v = -1; v_cnt = 0; ld_cnt = 0; ld_k1 = -1; ld_k2 = -1;
        for (int k = from; k <= NCYC; k++) begin
            if (pv_log[k] === 1'b1) begin
                if (first_v < 0) first_v = k;
                last_v = k;
                v_cnt++;
            end
            if (ld_log[k] === 1'b1) begin
                ld_cnt++;
                if (ld_k1 < 0) ld_k1 = k;
                else if (ld_k2 < 0) ld_k2 = k;
            end
        end
    endtask

    function automatic logic [7:0] got_byte(input int s, input int c);
        logic [7:0] b = '0;
        for (int i = 0; i < 8; i++) b = {b[6:0], px_log[s + 8*c + i]};
        return b;
    endfunction

    function automatic logic [7:0] exp_byte(input int row, input logic [3:0] line, input int c);
        logic [11:0] a = {cbuf[row*80 + c], line};
        return font[a];
    endfunction

    task automatic test_reset;
        rst_n = 1'b0;
        bus.line_start = 1'b0; bus.text_row = '0; bus.char_line = '0;
        bus.cursor_en = 1'b0; bus.cursor_blink = 1'b0; bus.cursor_col = '0; bus.cursor_row = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (bus.pixel !== 1'b0)       begin errors++; $display("FAIL reset_pixel: got %b want 0", bus.pixel); end
        checks++; if (bus.pixel_valid !== 1'b0) begin errors++; $display("FAIL reset_pixel_valid: got %b want 0", bus.pixel_valid); end
        checks++; if (bus.line_done !== 1'b0)   begin errors++; $display("FAIL reset_line_done: got %b want 0", bus.line_done); end
        checks++; if (bus.buf_addr !== 11'd0)   begin errors++; $display("FAIL reset_buf_addr: got %0d want 0", bus.buf_addr); end
        checks++; if (bus.font_addr !== 12'd0)  begin errors++; $display("FAIL reset_font_addr: got %0h want 0", bus.font_addr); end
    endtask

    task automatic test_basic;
        run_line(5'd0, 4'd3, 0, 5'd0, 4'd0);
        scan_logs(1);
        checks++; if (ba_log[1] !== 11'd0)     begin errors++; $display("FAIL basic_buf_addr_t1: got %0d want 0", ba_log[1]); end
        checks++; if (fa_log[3] !== 12'h413)   begin errors++; $display("FAIL basic_font_addr_t3: got %0h want 413", fa_log[3]); end
        checks++; if (first_v != 5)            begin errors++; $display("FAIL basic_first_valid: got %0d want 5", first_v); end
        checks++; if (last_v != 644)           begin errors++; $display("FAIL basic_last_valid: got %0d want 644", last_v); end
        checks++; if (v_cnt != 640)            begin errors++; $display("FAIL basic_valid_count: got %0d want 640", v_cnt); end
        checks++; if (ld_cnt != 1)             begin errors++; $display("FAIL basic_line_done_count: got %0d want 1", ld_cnt); end
        checks++; if (ld_k1 != 645)            begin errors++; $display("FAIL basic_line_done_cycle: got %0d want 645", ld_k1); end
        for (int c = 0; c < 80; c++) begin
            checks++;
            if (got_byte(5, c) !== 8'hA5) begin errors++; $display("FAIL basic_byte[%0d]: got %h want a5", c, got_byte(5, c)); end
        end
    endtask

    task automatic test_addr;
        run_line(5'd23, 4'd9, 0, 5'd0, 4'd0);
        scan_logs(1);
        checks++; if (ld_k1 != 645) begin errors++; $display("FAIL addr_line_done_cycle: got %0d want 645", ld_k1); end
        checks++; if (ba_log[1] !== 11'd1840) begin errors++; $display("FAIL addr_buf_col0: got %0d want 1840", ba_log[1]); end
        checks++; if (fa_log[3] !== {cbuf[1840], 4'd9}) begin errors++; $display("FAIL addr_font_col0: got %0h want %0h", fa_log[3], {cbuf[1840], 4'd9}); end
        for (int c = 1; c < 80; c++) begin
            checks++;
            if (ba_log[5 + 8*(c-1)] !== 11'(1840 + c)) begin
                errors++; $display("FAIL addr_buf_col[%0d]: got %0d want %0d", c, ba_log[5 + 8*(c-1)], 1840 + c);
            end
            checks++;
            if (fa_log[7 + 8*(c-1)] !== {cbuf[1840 + c], 4'd9}) begin
                errors++; $display("FAIL addr_font_col[%0d]: got %0h want %0h", c, fa_log[7 + 8*(c-1)], {cbuf[1840 + c], 4'd9});
            end
        end
        checks++; if (ba_log[644] !== 11'd1919) begin errors++; $display("FAIL addr_buf_hold_last: got %0d want 1919", ba_log[644]); end
        for (int c = 0; c < 80; c++) begin
            checks++;
            if (got_byte(5, c) !== exp_byte(23, 4'd9, c)) begin
                errors++; $display("FAIL addr_byte[%0d]: got %h want %h", c, got_byte(5, c), exp_byte(23, 4'd9, c));
            end
        end
    endtask

    task automatic test_clamp;
        run_line(5'd31, 4'd9, 0, 5'd0, 4'd0);
        checks++; if (ba_log[1] !== 11'd1840) begin errors++; $display("FAIL clamp_buf_col0: got %0d want 1840", ba_log[1]); end
        checks++; if (ba_log[629] !== 11'd1919) begin errors++; $display("FAIL clamp_buf_col79: got %0d want 1919", ba_log[629]); end
        for (int c = 0; c < 80; c += 13) begin
            checks++;
            if (got_byte(5, c) !== exp_byte(23, 4'd9, c)) begin
                errors++; $display("FAIL clamp_byte[%0d]: got %h want %h", c, got_byte(5, c), exp_byte(23, 4'd9, c));
            end
        end
    endtask

    task automatic cursor_run(input string name, input logic [4:0] row, input logic blink,
                              input logic [6:0] ccol, input int hit_col);
        logic [7:0] want;
        bus.cursor_en = 1'b1; bus.cursor_blink = blink; bus.cursor_col = ccol; bus.cursor_row = 5'd2;
        run_line(row, 4'd0, 0, 5'd0, 4'd0);
        for (int c = 0; c < 80; c++) begin
            want = (c == hit_col) ? 8'hFF : 8'h00;
            checks++;
            if (got_byte(5, c) !== want) begin
                errors++; $display("FAIL %s_byte[%0d]: got %h want %h", name, c, got_byte(5, c), want);
            end
        end
        bus.cursor_en = 1'b0; bus.cursor_blink = 1'b0;
    endtask

    task automatic test_cursor;
        cursor_run("cursor_on",    5'd2, 1'b1, 7'd5, 5);
        cursor_run("cursor_blink0", 5'd2, 1'b0, 7'd5, -1);
        cursor_run("cursor_row3",  5'd3, 1'b1, 7'd5, -1);
        cursor_run("cursor_col0",  5'd2, 1'b1, 7'd0, 0);
    endtask

    task automatic test_abort;
        run_line(5'd0, 4'd3, 105, 5'd23, 4'd9);
        checks++; if (pv_log[105] !== 1'b1) begin errors++; $display("FAIL abort_valid_at_pix100: got %b want 1", pv_log[105]); end
        scan_logs(1);
        checks++; if (ld_cnt != 1)   begin errors++; $display("FAIL abort_line_done_count: got %0d want 1", ld_cnt); end
        checks++; if (ld_k1 != 750)  begin errors++; $display("FAIL abort_line_done_cycle: got %0d want 750", ld_k1); end
        scan_logs(106);
        checks++; if (first_v != 110) begin errors++; $display("FAIL abort_new_first_valid: got %0d want 110", first_v); end
        checks++; if (v_cnt != 640)   begin errors++; $display("FAIL abort_new_valid_count: got %0d want 640", v_cnt); end
        for (int c = 0; c < 80; c++) begin
            checks++;
            if (got_byte(110, c) !== exp_byte(23, 4'd9, c)) begin
                errors++; $display("FAIL abort_byte[%0d]: got %h want %h", c, got_byte(110, c), exp_byte(23, 4'd9, c));
            end
        end
    endtask

    task automatic test_back_to_back;
        run_line(5'd0, 4'd3, 646, 5'd23, 4'd9);
        scan_logs(1);
        checks++; if (ld_cnt != 2)    begin errors++; $display("FAIL b2b_line_done_count: got %0d want 2", ld_cnt); end
        checks++; if (ld_k1 != 645)   begin errors++; $display("FAIL b2b_line_done_1: got %0d want 645", ld_k1); end
        checks++; if (ld_k2 != 1291)  begin errors++; $display("FAIL b2b_line_done_2: got %0d want 1291", ld_k2); end
        scan_logs(645);
        checks++; if (first_v != 651) begin errors++; $display("FAIL b2b_first_valid: got %0d want 651", first_v); end
        checks++; if (v_cnt != 640)   begin errors++; $display("FAIL b2b_valid_count: got %0d want 640", v_cnt); end
        for (int c = 0; c < 80; c++) begin
            checks++;
            if (got_byte(651, c) !== exp_byte(23, 4'd9, c)) begin
                errors++; $display("FAIL b2b_byte[%0d]: got %h want %h", c, got_byte(651, c), exp_byte(23, 4'd9, c));
            end
        end
    endtask

    task automatic test_reset_mid;
        int pv_seen;
        @(negedge clk);
        bus.text_row = 5'd0; bus.char_line = 4'd3; bus.line_start = 1'b1;
        @(negedge clk);
        bus.line_start = 1'b0;
        repeat (201) @(negedge clk);                 // cycle t+202: pixel 197, bit 5 of a5 = 1
        checks++; if (bus.pixel_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre_valid: got %b want 1", bus.pixel_valid); end
        checks++; if (bus.pixel !== 1'b1)       begin errors++; $display("FAIL rstmid_pre_pixel: got %b want 1", bus.pixel); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.pixel_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b want 0", bus.pixel_valid); end
        checks++; if (bus.pixel !== 1'b0)       begin errors++; $display("FAIL rstmid_pixel: got %b want 0", bus.pixel); end
        checks++; if (bus.line_done !== 1'b0)   begin errors++; $display("FAIL rstmid_line_done: got %b want 0", bus.line_done); end
        checks++; if (bus.buf_addr !== 11'd0)   begin errors++; $display("FAIL rstmid_buf_addr: got %0d want 0", bus.buf_addr); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pv_seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.pixel_valid !== 1'b0 || bus.line_done !== 1'b0) pv_seen++;
        end
        checks++; if (pv_seen != 0) begin errors++; $display("FAIL rstmid_idle_after: got %0d active cycles want 0", pv_seen); end
        run_line(5'd0, 4'd3, 0, 5'd0, 4'd0);
        scan_logs(1);
        checks++; if (first_v != 5)  begin errors++; $display("FAIL rstmid_restart_first: got %0d want 5", first_v); end
        checks++; if (ld_k1 != 645)  begin errors++; $display("FAIL rstmid_restart_done: got %0d want 645", ld_k1); end
        checks++; if (got_byte(5, 0) !== 8'hA5) begin errors++; $display("FAIL rstmid_restart_byte0: got %h want a5", got_byte(5, 0)); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 4096; i++) font[i] = 8'((i * 37 + (i >> 4)) & 255);
        font[{8'h41, 4'd3}] = 8'hA5;
        font[{8'h20, 4'd0}] = 8'h00;
        for (int i = 0; i < 2048; i++) cbuf[i] = 8'h20;
        for (int c = 0; c < 80; c++) begin
            cbuf[c]           = 8'h41;
            cbuf[80 + c]      = 8'h41;
            cbuf[23*80 + c]   = 8'(c * 3 + 1);
        end

        test_reset;
        test_basic;
        test_addr;
        test_clamp;
        test_cursor;
        test_abort;
        test_back_to_back;
        test_reset_mid;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
